// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of a single UART_TX transmitter.
// It takes one byte per grant over a valid/ready handshake, launches the
// transmitter with a one-cycle tx_start, and holds the byte until the frame
// completes or the watchdog aborts it. It then idles for GAP_CYCLES cycles.
//
// Ports:
//   clk, Reset      clock; asynchronous active-high reset
//   enable          low blocks new grants; a frame in flight still completes
//   req_valid       per-requester byte-available flags
//   req_data        requester i's byte is req_data[i*DATA_W +: DATA_W]
//   req_ready       one-hot accept, combinational, asserted only in IDLE
//   tx_start        one-cycle launch pulse to the transmitter
//   tx_data         byte to the transmitter, held from capture to next capture
//   tx_done_tick    frame-complete tick from the transmitter
//   busy            high in every state except IDLE
//   grant_id        owner of the current or most recent frame
//   done_valid      one-cycle pulse on normal frame completion
//   timeout_err     one-cycle pulse on watchdog abort
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_done_tick,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       done_valid,
    output logic                       timeout_err
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [ID_W-1:0] ID_MAX  = ID_W'(N_REQ - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     grant_d;
    logic [DATA_W-1:0]   data_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GP_W-1:0]     gp_q, gp_d;
    logic                start_d, busy_d, done_d, to_d;

    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     cand;
    logic                found;
    logic                take;

    // Round-robin search starting just above the last grant, wrapping once.
    always_comb begin
        winner = last_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Reset gating keeps req_ready low while Reset holds the FSM in IDLE.
    assign take = (state_q == S_IDLE) && enable && found && !Reset;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_id;
        data_d    = tx_data;
        wd_d      = wd_q;
        gp_d      = gp_q;
        done_d    = 1'b0;
        to_d      = 1'b0;
        req_ready = '0;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    req_ready[winner] = 1'b1;
                    last_d            = winner;
                    grant_d           = winner;
                    data_d            = req_data[32'(winner) * DATA_W +: DATA_W];
                    state_d           = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A done tick on the expiry cycle counts as a normal completion.
                if (tx_done_tick) begin
                    done_d  = 1'b1;
                    gp_d    = '0;
                    state_d = S_GAP;
                end else if (wd_q == WD_LAST) begin
                    to_d    = 1'b1;
                    gp_d    = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gp_q == GP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gp_d = gp_q + GP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            last_q      <= ID_MAX;
            grant_id    <= '0;
            tx_data     <= '0;
            wd_q        <= '0;
            gp_q        <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_id    <= grant_d;
            tx_data     <= data_d;
            wd_q        <= wd_d;
            gp_q        <= gp_d;
            tx_start    <= start_d;
            busy        <= busy_d;
            done_valid  <= done_d;
            timeout_err <= to_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a timeline
// model (grant cycle, result cycle, idle cycle) checked every clock, plus
// hand-computed literal checks for each scenario.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam int unsigned T = 10;
    localparam int unsigned G = 2;

    logic           clk = 1'b0;
    logic           Reset;
    logic           enable;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_done_tick;
    logic           busy;
    logic [1:0]     grant_id;
    logic           done_valid;
    logic           timeout_err;

    int n_vec = 0;
    int n_bad = 0;

    // Timeline model: everything is expressed as absolute cycle numbers.
    int         cyc = 0;
    bit         m_act = 1'b0;
    int         m_g = 0;
    bit         m_known = 1'b0;
    bit         m_to = 1'b0;
    int         m_end = 0;
    int         m_free = 0;
    int         m_last = N - 1;
    int         m_gid = 0;
    logic [W-1:0] m_data = '0;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .enable(enable),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done_tick(tx_done_tick),
        .busy(busy),
        .grant_id(grant_id),
        .done_valid(done_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int i;
        logic [N-1:0] sh;
        for (int k = 1; k <= int'(N); k++) begin
            i  = (last + k) % int'(N);
            sh = v >> i;
            if (sh[0]) return i;
        end
        return -1;
    endfunction

    // Compare DUT outputs with the model for this cycle, then advance the model.
    task automatic model_step();
        logic [N-1:0] e_ready;
        int  pick;
        bit  idle;
        cyc++;
        if (Reset) begin
            chk("m_rst_ready", 32'(req_ready), 0);
            chk("m_rst_start", 32'(tx_start), 0);
            chk("m_rst_busy", 32'(busy), 0);
            chk("m_rst_done", 32'(done_valid), 0);
            chk("m_rst_timeout", 32'(timeout_err), 0);
            chk("m_rst_data", 32'(tx_data), 0);
            chk("m_rst_gid", 32'(grant_id), 0);
            m_act   = 1'b0;
            m_known = 1'b0;
            m_last  = N - 1;
            m_gid   = 0;
            m_data  = '0;
            return;
        end
        idle = !m_act || (m_known && cyc >= m_free);
        if (idle) m_act = 1'b0;
        pick = rr_pick(m_last, req_valid);
        e_ready = '0;
        if (idle && enable && pick >= 0) e_ready = N'(1) << pick;

        chk("m_ready", 32'(req_ready), 32'(e_ready));
        chk("m_busy", 32'(busy), 32'(!idle));
        chk("m_start", 32'(tx_start), 32'(m_act && cyc == m_g + 1));
        chk("m_done", 32'(done_valid), 32'(m_act && m_known && !m_to && cyc == m_end));
        chk("m_timeout", 32'(timeout_err), 32'(m_act && m_known && m_to && cyc == m_end));
        chk("m_data", 32'(tx_data), 32'(m_data));
        chk("m_gid", 32'(grant_id), m_gid);

        if (idle && enable && pick >= 0) begin
            m_act   = 1'b1;
            m_g     = cyc;
            m_known = 1'b0;
            m_last  = pick;
            m_gid   = pick;
            m_data  = W'(req_data >> (pick * int'(W)));
        end else if (m_act && !m_known && cyc >= m_g + 2) begin
            // Waiting starts two cycles after the grant; the watchdog allows T cycles.
            if (tx_done_tick) begin
                m_known = 1'b1;
                m_to    = 1'b0;
                m_end   = cyc + 1;
            end else if (cyc == m_g + 1 + int'(T)) begin
                m_known = 1'b1;
                m_to    = 1'b1;
                m_end   = cyc + 1;
            end
            if (m_known) m_free = m_end + int'(G);
        end
    endtask

    // One clock: model check at the falling edge, then land 1 time unit after the rise.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(tx_start), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk("idle_seen", 32'(busy), 0);
    endtask

    // From the LAUNCH cycle: two WAIT cycles, then a done tick.
    task automatic finish_frame();
        tick();
        tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("frame_done", 32'(done_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;

        Reset        = 1'b1;
        enable       = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        tx_done_tick = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        Reset = 1'b0;

        // Single request on lane 2.
        req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h4);
        tick();
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_gid", 32'(grant_id), 2);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready_launch", 32'(req_ready), 0);
        req_valid = '0;
        tick();
        chk("t1_start_once", 32'(tx_start), 0);
        tick();
        tick();
        chk("t1_data_held", 32'(tx_data), 32'hA5);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("t1_done", 32'(done_valid), 1);
        chk("t1_done_gid", 32'(grant_id), 2);
        chk("t1_no_timeout", 32'(timeout_err), 0);
        wait_idle();

        // Round-robin fairness from reset with all lanes valid.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            wait_start();
            chk("rr_order", 32'(grant_id), exp_order[f]);
            chk("rr_data", 32'(tx_data), 32'h10 + 32'(grant_id));
            if (f == 4) req_valid = '0;
            finish_frame();
        end
        wait_idle();

        // Watchdog expiry with no done tick.
        req_valid = 4'b0001;
        wait_start();
        chk("wd_gid", 32'(grant_id), 0);
        req_valid = '0;
        tick();
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 10);
        chk("wd_no_done", 32'(done_valid), 0);
        tick();
        chk("wd_pulse_once", 32'(timeout_err), 0);
        chk("wd_gap_busy", 32'(busy), 1);
        wait_idle();

        // Done tick on the expiry cycle: done wins.
        req_valid = 4'b0010;
        wait_start();
        req_valid = '0;
        tick();
        repeat (9) tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("sim_done", 32'(done_valid), 1);
        chk("sim_timeout", 32'(timeout_err), 0);
        tick();
        chk("sim_timeout_late", 32'(timeout_err), 0);
        wait_idle();

        // Enable dropped mid-WAIT, then stray ticks in IDLE, then resume.
        req_valid = 4'b1000;
        wait_start();
        chk("en_gid", 32'(grant_id), 3);
        req_valid = '0;
        tick();
        enable    = 1'b0;
        req_valid = 4'hF;
        tick();
        chk("en_ready_wait", 32'(req_ready), 0);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("en_done", 32'(done_valid), 1);
        wait_idle();
        repeat (4) begin
            tick();
            chk("en_low_ready", 32'(req_ready), 0);
            chk("en_low_busy", 32'(busy), 0);
        end
        tx_done_tick = 1'b1;
        repeat (3) begin
            tick();
            chk("stray_done", 32'(done_valid), 0);
            chk("stray_busy", 32'(busy), 0);
        end
        tx_done_tick = 1'b0;
        enable = 1'b1;
        #1;
        chk("en_resume_ready", 32'(req_ready), 32'h1);
        tick();
        chk("en_resume_gid", 32'(grant_id), 0);
        chk("en_resume_start", 32'(tx_start), 1);
        req_valid = '0;
        finish_frame();
        wait_idle();

        // Reset during WAIT.
        req_valid = 4'b0100;
        wait_start();
        req_valid = '0;
        tick();
        tick();
        Reset     = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("mr_start", 32'(tx_start), 0);
        chk("mr_ready", 32'(req_ready), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done_valid), 0);
        chk("mr_timeout", 32'(timeout_err), 0);
        chk("mr_data", 32'(tx_data), 0);
        chk("mr_gid", 32'(grant_id), 0);
        tick();
        Reset = 1'b0;
        #1;
        chk("mr_after_ready", 32'(req_ready), 32'h2);
        tick();
        chk("mr_after_gid", 32'(grant_id), 1);
        chk("mr_after_start", 32'(tx_start), 1);
        chk("mr_after_data", 32'(tx_data), 32'h11);
        req_valid = '0;
        finish_frame();
        wait_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
